// File: rtl/alarm_pkg.sv
// alarm_pkg -- shared definitions for the multi_alarm block.
// Holds the alarm FSM state encoding and the time-of-day constants
// used by the channel registers and the top-level controller.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } alarm_state_t;

    localparam int unsigned MAX_HOUR    = 23;
    localparam int unsigned MAX_MIN     = 59;
    localparam int unsigned SEC_PER_MIN = 60;
    localparam int unsigned TIME_W      = 14;

endpackage

// File: rtl/alarm_channel.sv
// alarm_channel -- one alarm channel: stored hour/minute, arm flag,
// setting logic and the time-match comparator.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   sel               this channel is the one selected by set_sel
//   set_en            setting mode; inc/arm_toggle ignored when 0
//   set_hr_or_min     0 = inc acts on hour, 1 = inc acts on minute
//   inc, arm_toggle   single-cycle setting pulses
//   sec_tick          once-per-second pulse
//   hour_in, minute_in, second_in  current time (binary)
//   alarm_hr, alarm_min            stored time, zero-extended
//   armed             arm flag
//   match             combinational match on the current sec_tick
module alarm_channel
    import alarm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              set_en,
    input  logic              set_hr_or_min,
    input  logic              inc,
    input  logic              arm_toggle,
    input  logic              sec_tick,
    input  logic [TIME_W-1:0] hour_in,
    input  logic [TIME_W-1:0] minute_in,
    input  logic [TIME_W-1:0] second_in,
    output logic [TIME_W-1:0] alarm_hr,
    output logic [TIME_W-1:0] alarm_min,
    output logic              armed,
    output logic              match
);

    logic [4:0] hour_q;
    logic [5:0] minute_q;
    logic       armed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hour_q   <= '0;
            minute_q <= '0;
            armed_q  <= 1'b0;
        end else if (sel && set_en) begin
            if (inc) begin
                if (!set_hr_or_min)
                    hour_q <= (hour_q == 5'(MAX_HOUR)) ? '0 : hour_q + 5'd1;
                else
                    minute_q <= (minute_q == 6'(MAX_MIN)) ? '0 : minute_q + 6'd1;
            end
            if (arm_toggle)
                armed_q <= ~armed_q;
        end
    end

    assign alarm_hr  = {{(TIME_W-5){1'b0}}, hour_q};
    assign alarm_min = {{(TIME_W-6){1'b0}}, minute_q};
    assign armed     = armed_q;

    assign match = sec_tick && armed_q &&
                   (hour_in   == alarm_hr) &&
                   (minute_in == alarm_min) &&
                   (second_in == '0);

endmodule

// File: rtl/multi_alarm.sv
// multi_alarm -- NUM_ALARMS independent alarm channels sharing one
// ring/snooze controller.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   sec_tick                       once-per-second pulse
//   hour_in, minute_in, second_in  current time (binary)
//   set_en, set_sel, set_hr_or_min, inc, arm_toggle   channel setting
//   snooze, dismiss                ring control pulses
//   alarm_hr_out, alarm_min_out    stored time of channel set_sel
//   armed                          per-channel arm flags
//   ringing_ch                     channel ringing or snoozed
//   beep                           2 Hz on/off tone while ringing
//   snoozed                        high while snoozed
// Build option: define MULTI_ALARM_SNOOZE_EN to enable snooze and the
// SNOOZED state; without it snooze is ignored and snoozed is 0.
module multi_alarm
    import alarm_pkg::*;
#(
    parameter int unsigned NUM_ALARMS = 4,
    parameter int unsigned CLK_HZ     = 10000,
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_MIN = 5,
    localparam int unsigned CH_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sec_tick,
    input  logic [13:0]           hour_in,
    input  logic [13:0]           minute_in,
    input  logic [13:0]           second_in,
    input  logic                  set_en,
    input  logic [CH_W-1:0]       set_sel,
    input  logic                  set_hr_or_min,
    input  logic                  inc,
    input  logic                  arm_toggle,
    input  logic                  snooze,
    input  logic                  dismiss,
    output logic [13:0]           alarm_hr_out,
    output logic [13:0]           alarm_min_out,
    output logic [NUM_ALARMS-1:0] armed,
    output logic [CH_W-1:0]       ringing_ch,
    output logic                  beep,
    output logic                  snoozed
);

    localparam int unsigned RING_W    = $clog2(RING_SEC + 1);
    localparam int unsigned BEEP_HALF = CLK_HZ / 4;
    localparam int unsigned BEEP_W    = $clog2(BEEP_HALF + 1);

    logic [13:0]           ch_hr  [NUM_ALARMS];
    logic [13:0]           ch_min [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] match;

    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
        alarm_channel u_ch (
            .clk           (clk),
            .rst           (rst),
            .sel           (set_sel == CH_W'(g)),
            .set_en        (set_en),
            .set_hr_or_min (set_hr_or_min),
            .inc           (inc),
            .arm_toggle    (arm_toggle),
            .sec_tick      (sec_tick),
            .hour_in       (hour_in),
            .minute_in     (minute_in),
            .second_in     (second_in),
            .alarm_hr      (ch_hr[g]),
            .alarm_min     (ch_min[g]),
            .armed         (armed[g]),
            .match         (match[g])
        );
    end

    assign alarm_hr_out  = (32'(set_sel) < NUM_ALARMS) ? ch_hr[set_sel]  : '0;
    assign alarm_min_out = (32'(set_sel) < NUM_ALARMS) ? ch_min[set_sel] : '0;

    // Priority encoder: lowest matching channel wins.
    logic            any_match;
    logic [CH_W-1:0] first_idx;

    always_comb begin
        any_match = 1'b0;
        first_idx = '0;
        for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
            if (match[i] && !any_match) begin
                any_match = 1'b1;
                first_idx = CH_W'(i);
            end
        end
    end

    alarm_state_t        state, state_nxt;
    logic [RING_W-1:0]   ring_cnt;
    logic [BEEP_W-1:0]   beep_cnt;
    logic                beep_q;
    logic                ring_abort;

    // Dismiss or disarming the active channel overrides everything else.
    assign ring_abort = dismiss || !armed[ringing_ch];

`ifdef MULTI_ALARM_SNOOZE_EN
    localparam int unsigned SNZ_LOAD = SNOOZE_MIN * SEC_PER_MIN;
    localparam int unsigned SNZ_W    = $clog2(SNZ_LOAD + 1);
    logic [SNZ_W-1:0] snz_cnt;
`else
    logic unused_snooze;
    assign unused_snooze = snooze;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_match) state_nxt = RINGING;
            end
            RINGING: begin
                if (ring_abort)
                    state_nxt = IDLE;
`ifdef MULTI_ALARM_SNOOZE_EN
                else if (snooze)
                    state_nxt = SNOOZED;
`endif
                else if (sec_tick && ring_cnt == RING_W'(RING_SEC - 1))
                    state_nxt = IDLE;
            end
`ifdef MULTI_ALARM_SNOOZE_EN
            SNOOZED: begin
                if (ring_abort)
                    state_nxt = IDLE;
                else if (sec_tick && snz_cnt == SNZ_W'(1))
                    state_nxt = RINGING;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    logic entering_ring;
    assign entering_ring = (state_nxt == RINGING) && (state != RINGING);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ringing_ch <= '0;
            ring_cnt   <= '0;
            beep_cnt   <= '0;
            beep_q     <= 1'b0;
        end else begin
            if (state == IDLE && any_match)
                ringing_ch <= first_idx;

            if (entering_ring)
                ring_cnt <= '0;
            else if (state == RINGING && sec_tick)
                ring_cnt <= ring_cnt + RING_W'(1);

            // Tone phase restarts high on every entry into RINGING.
            if (entering_ring) begin
                beep_q   <= 1'b1;
                beep_cnt <= '0;
            end else if (state == RINGING) begin
                if (beep_cnt == BEEP_W'(BEEP_HALF - 1)) begin
                    beep_q   <= ~beep_q;
                    beep_cnt <= '0;
                end else begin
                    beep_cnt <= beep_cnt + BEEP_W'(1);
                end
            end else begin
                beep_q   <= 1'b0;
                beep_cnt <= '0;
            end
        end
    end

`ifdef MULTI_ALARM_SNOOZE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            snz_cnt <= '0;
        else if (state == RINGING && state_nxt == SNOOZED)
            snz_cnt <= SNZ_W'(SNZ_LOAD);
        else if (state == SNOOZED && sec_tick && snz_cnt != '0)
            snz_cnt <= snz_cnt - SNZ_W'(1);
    end
`endif

    always_comb begin
        beep    = (state == RINGING) && beep_q;
        snoozed = 1'b0;
`ifdef MULTI_ALARM_SNOOZE_EN
        snoozed = (state == SNOOZED);
`endif
    end

endmodule
